// File: rtl/led_bar_pkg.sv
// Shared definitions for the LED bar controller.
// Holds the wrap-mode constants, the repeat FSM state type and the
// level-to-thermometer decode used by the top level.
package led_bar_pkg;

    // Wrap-mode selectors for the WRAP parameter.
    localparam int WRAP_SATURATE = 0;
    localparam int WRAP_AROUND   = 1;

    // Largest supported bar and the level width needed to hold it.
    localparam int MAX_WIDTH = 32;
    localparam int MAX_LW    = 6;

    // Auto-repeat sequencing of a single button.
    // REP_IDLE  : no press in progress, or the button has been held since reset.
    // REP_DELAY : waiting out the initial hold time after a press.
    // REP_REPEAT: stepping at the repeat rate until release.
    typedef enum logic [1:0] {
        REP_IDLE   = 2'd0,
        REP_DELAY  = 2'd1,
        REP_REPEAT = 2'd2
    } repeatState_e;

    // Thermometer decode: bits [lvl-1:0] set, the rest clear.
    // Levels of MAX_WIDTH or more light every bit.
    function automatic logic [MAX_WIDTH-1:0] levelToBar(input logic [MAX_LW-1:0] lvl);
        logic [MAX_WIDTH-1:0] bar;
        bar = '0;
        for (int i = 0; i < MAX_WIDTH; i++) begin
            bar[i] = (i < int'(lvl));
        end
        return bar;
    endfunction

endpackage

// File: rtl/led_bar_controller_button_conditioner.sv
// Conditions one raw, asynchronous push button into single-cycle step pulses.
// The button is synchronised through two flops, its rising edge becomes the
// first step, and holding it produces auto-repeat steps after an initial
// delay and then at a fixed rate until it is released.
module button_conditioner
    import led_bar_pkg::*;
#(
    parameter int REPEAT_DELAY = 16,
    parameter int REPEAT_RATE  = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_i,
    output logic step_o
);

    // The counter only has to reach the larger of the two hold intervals.
    localparam int CNT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int CW      = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0] DELAY_TARGET = CW'(REPEAT_DELAY);
    localparam logic [CW-1:0] RATE_TARGET  = CW'(REPEAT_RATE);
    localparam logic [CW-1:0] CNT_ONE      = CW'(1);
    localparam logic [CW-1:0] CNT_FULL     = {CW{1'b1}};

    logic         syncMeta_q;
    logic         syncStable_q;
    logic         syncPrev_q;
    logic         press;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic [CW-1:0] cntInc;
    repeatState_e  state_q;
    repeatState_e  state_d;

    // Synchroniser and edge-detect flops reset high so a button held through
    // reset looks like it was already pressed and cannot create a step.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            syncMeta_q   <= 1'b1;
            syncStable_q <= 1'b1;
            syncPrev_q   <= 1'b1;
        end else begin
            syncMeta_q   <= btn_i;
            syncStable_q <= syncMeta_q;
            syncPrev_q   <= syncStable_q;
        end
    end

    assign press  = syncStable_q & ~syncPrev_q;
    assign cntInc = (cnt_q == CNT_FULL) ? cnt_q : cnt_q + CNT_ONE;

    // Repeat state and hold counter; reset aborts any repeat in progress.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= REP_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next repeat state: release always returns to idle with a cleared counter.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (!syncStable_q) begin
            state_d = REP_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                REP_IDLE: begin
                    if (press && (REPEAT_DELAY > 0)) begin
                        state_d = REP_DELAY;
                        cnt_d   = CNT_ONE;
                    end
                end
                REP_DELAY: begin
                    if (cnt_q == DELAY_TARGET) begin
                        state_d = REP_REPEAT;
                        cnt_d   = CNT_ONE;
                    end else begin
                        cnt_d = cntInc;
                    end
                end
                REP_REPEAT: begin
                    if (cnt_q == RATE_TARGET) begin
                        cnt_d = CNT_ONE;
                    end else begin
                        cnt_d = cntInc;
                    end
                end
                default: begin
                    state_d = REP_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Step pulse: the press itself, then each expiry of the delay or rate
    // interval, but only while the button is still held.
    always_comb begin
        step_o = 1'b0;
        if (syncStable_q) begin
            case (state_q)
                REP_IDLE:   step_o = press;
                REP_DELAY:  step_o = (cnt_q == DELAY_TARGET);
                REP_REPEAT: step_o = (cnt_q == RATE_TARGET);
                default:    step_o = 1'b0;
            endcase
        end
    end

endmodule

// File: rtl/led_bar_controller.sv
// LED bar level controller.
// Two conditioned buttons step a level up and down between MIN_LEVEL and
// WIDTH (saturating or wrapping), a load strobe sets it directly, and the
// bar, at_max and at_min outputs are pure decodes of that single level register.
module led_bar_controller
    import led_bar_pkg::*;
#(
    parameter int WIDTH        = 8,
    parameter int MIN_LEVEL    = 1,
    parameter int WRAP         = 0,
    parameter int REPEAT_DELAY = 16,
    parameter int REPEAT_RATE  = 4,
    localparam int LW          = $clog2(WIDTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          up_btn,
    input  logic          down_btn,
    input  logic          load,
    input  logic [LW-1:0] load_level,
    output logic [WIDTH-1:0] Q,
    output logic [LW-1:0] level,
    output logic          at_max,
    output logic          at_min
);

    localparam logic [LW-1:0] MAX_LVL = LW'(WIDTH);
    localparam logic [LW-1:0] MIN_LVL = LW'(MIN_LEVEL);
    localparam logic [LW-1:0] LVL_ONE = LW'(1);

    logic          upStep;
    logic          downStep;
    logic [LW-1:0] level_q;
    logic [LW-1:0] level_d;

    button_conditioner #(
        .REPEAT_DELAY (REPEAT_DELAY),
        .REPEAT_RATE  (REPEAT_RATE)
    ) upCond (
        .clk    (clk),
        .reset  (reset),
        .btn_i  (up_btn),
        .step_o (upStep)
    );

    button_conditioner #(
        .REPEAT_DELAY (REPEAT_DELAY),
        .REPEAT_RATE  (REPEAT_RATE)
    ) downCond (
        .clk    (clk),
        .reset  (reset),
        .btn_i  (down_btn),
        .step_o (downStep)
    );

    // Next level: load wins, a lone up or down step moves, simultaneous steps cancel.
    always_comb begin
        level_d = level_q;
        if (load) begin
            if (load_level < MIN_LVL) begin
                level_d = MIN_LVL;
            end else if (load_level > MAX_LVL) begin
                level_d = MAX_LVL;
            end else begin
                level_d = load_level;
            end
        end else if (upStep && !downStep) begin
            if (level_q == MAX_LVL) begin
                level_d = (WRAP == WRAP_AROUND) ? MIN_LVL : MAX_LVL;
            end else begin
                level_d = level_q + LVL_ONE;
            end
        end else if (downStep && !upStep) begin
            if (level_q == MIN_LVL) begin
                level_d = (WRAP == WRAP_AROUND) ? MAX_LVL : MIN_LVL;
            end else begin
                level_d = level_q - LVL_ONE;
            end
        end
    end

    // The level register is the only bar state; reset returns it to the floor.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            level_q <= MIN_LVL;
        end else begin
            level_q <= level_d;
        end
    end

    assign level  = level_q;
    assign Q      = WIDTH'(levelToBar(MAX_LW'(level_q)));
    assign at_max = (level_q == MAX_LVL);
    assign at_min = (level_q == MIN_LVL);

endmodule

// File: tb/tb_led_bar_controller.sv
// Testbench for led_bar_controller.
// Drives a saturating and a wrapping instance from the same buttons; a
// reference model predicts both levels each clock into a queue and a
// negedge monitor pops and compares the bar, level and end flags.
module tb_led_bar_controller;

    localparam int W    = 8;
    localparam int MINL = 1;
    localparam int RD   = 16;
    localparam int RR   = 4;
    localparam int LW   = 4;

    typedef struct {
        int lvl0;
        int lvl1;
    } expect_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          upBtn;
    logic          downBtn;
    logic          load;
    logic [LW-1:0] loadLevel;

    logic [W-1:0]  q0;
    logic [W-1:0]  q1;
    logic [LW-1:0] level0;
    logic [LW-1:0] level1;
    logic          atMax0;
    logic          atMin0;
    logic          atMax1;
    logic          atMin1;

    int checks = 0;
    int errors = 0;

    expect_t expQ[$];

    int mLvl0;
    int mLvl1;
    int upHeld;
    int dnHeld;
    bit upH1, upH2, upH3;
    bit dnH1, dnH2, dnH3;

    always #5 clk = ~clk;

    led_bar_controller #(
        .WIDTH(W), .MIN_LEVEL(MINL), .WRAP(0), .REPEAT_DELAY(RD), .REPEAT_RATE(RR)
    ) dut0 (
        .clk(clk), .reset(reset), .up_btn(upBtn), .down_btn(downBtn),
        .load(load), .load_level(loadLevel),
        .Q(q0), .level(level0), .at_max(atMax0), .at_min(atMin0)
    );

    led_bar_controller #(
        .WIDTH(W), .MIN_LEVEL(MINL), .WRAP(1), .REPEAT_DELAY(RD), .REPEAT_RATE(RR)
    ) dut1 (
        .clk(clk), .reset(reset), .up_btn(upBtn), .down_btn(downBtn),
        .load(load), .load_level(loadLevel),
        .Q(q1), .level(level1), .at_max(atMax1), .at_min(atMin1)
    );

    // Decide whether a held button steps this clock, from how long it has been
    // held since its press (held < 0 means held since reset, never pressed).
    function automatic bit evalButton(input bit cur, input bit prev, inout int held);
        if (!cur) begin
            held = -1;
            return 1'b0;
        end
        if (!prev) begin
            held = 0;
            return 1'b1;
        end
        if (held < 0) return 1'b0;
        held = held + 1;
        return (RD > 0) && (held >= RD) && (((held - RD) % RR) == 0);
    endfunction

    function automatic int moveLevel(input int lvl, input bit isUp, input bit wrap);
        if (isUp) begin
            if (lvl == W) return wrap ? MINL : W;
            return lvl + 1;
        end
        if (lvl == MINL) return wrap ? W : MINL;
        return lvl - 1;
    endfunction

    function automatic int clampLoad(input int v);
        if (v < MINL) return MINL;
        if (v > W) return W;
        return v;
    endfunction

    function automatic logic [W-1:0] expBar(input int lvl);
        logic [15:0] t;
        t = (16'd1 << lvl) - 16'd1;
        return t[W-1:0];
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic u, input logic d, input int cycles);
        upBtn   = u;
        downBtn = d;
        repeat (cycles) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic doLoad(input int v);
        load      = 1'b1;
        loadLevel = LW'(v);
        @(posedge clk);
        #2;
        load = 1'b0;
    endtask

    // Reference model: one prediction per rising edge, pushed to the scoreboard.
    initial begin
        bit us;
        bit ds;
        forever begin
            @(posedge clk);
            if (!reset) begin
                mLvl0 = MINL;
                mLvl1 = MINL;
                {upH1, upH2, upH3} = 3'b111;
                {dnH1, dnH2, dnH3} = 3'b111;
                upHeld = -1;
                dnHeld = -1;
            end else begin
                us = evalButton(upH2, upH3, upHeld);
                ds = evalButton(dnH2, dnH3, dnHeld);
                if (load) begin
                    mLvl0 = clampLoad(int'(loadLevel));
                    mLvl1 = clampLoad(int'(loadLevel));
                end else if (us != ds) begin
                    mLvl0 = moveLevel(mLvl0, us, 1'b0);
                    mLvl1 = moveLevel(mLvl1, us, 1'b1);
                end
                upH3 = upH2; upH2 = upH1; upH1 = upBtn;
                dnH3 = dnH2; dnH2 = dnH1; dnH1 = downBtn;
            end
            expQ.push_back('{mLvl0, mLvl1});
        end
    end

    // Monitor: compare every output of both instances against the oldest prediction.
    initial begin
        expect_t e;
        forever begin
            @(negedge clk);
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                if (!reset) e = '{MINL, MINL};
                checkOutput("level wrap0", int'(level0), e.lvl0);
                checkOutput("bar wrap0", int'(q0), int'(expBar(e.lvl0)));
                checkOutput("at_max wrap0", int'(atMax0), int'(e.lvl0 == W));
                checkOutput("at_min wrap0", int'(atMin0), int'(e.lvl0 == MINL));
                checkOutput("level wrap1", int'(level1), e.lvl1);
                checkOutput("bar wrap1", int'(q1), int'(expBar(e.lvl1)));
                checkOutput("at_max wrap1", int'(atMax1), int'(e.lvl1 == W));
                checkOutput("at_min wrap1", int'(atMin1), int'(e.lvl1 == MINL));
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not complete, errors %0d", errors);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic u;
        logic d;
        int   len;

        upBtn     = 1'b0;
        downBtn   = 1'b0;
        load      = 1'b0;
        loadLevel = '0;
        reset     = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        reset = 1'b1;
        applyStimulus(1'b0, 1'b0, 4);
        checkOutput("reset level", int'(level0), 1);
        checkOutput("reset bar", int'(q0), 8'h01);
        checkOutput("reset at_min", int'(atMin0), 1);
        checkOutput("reset at_max", int'(atMax0), 0);

        // Three short presses from the floor.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b0, 3);
            applyStimulus(1'b0, 1'b0, 4);
        end
        checkOutput("three presses level", int'(level0), 4);
        checkOutput("three presses bar", int'(q0), 8'h0F);
        checkOutput("three presses at_min", int'(atMin0), 0);

        // Long hold: press step, first repeat after 16, then every 4, saturating.
        applyStimulus(1'b1, 1'b0, 100);
        checkOutput("hold saturate level", int'(level0), 8);
        checkOutput("hold saturate bar", int'(q0), 8'hFF);
        checkOutput("hold saturate at_max", int'(atMax0), 1);
        applyStimulus(1'b0, 1'b0, 5);

        // Wrap at both ends.
        doLoad(8);
        checkOutput("load 8 wrap1", int'(level1), 8);
        applyStimulus(1'b1, 1'b0, 3);
        applyStimulus(1'b0, 1'b0, 4);
        checkOutput("wrap up level", int'(level1), 1);
        checkOutput("wrap up bar", int'(q1), 8'h01);
        checkOutput("saturate up level", int'(level0), 8);
        applyStimulus(1'b0, 1'b1, 3);
        applyStimulus(1'b0, 1'b0, 4);
        checkOutput("wrap down level", int'(level1), 8);
        checkOutput("plain down level", int'(level0), 7);

        // Simultaneous steps cancel; load clamps both ways.
        doLoad(5);
        applyStimulus(1'b1, 1'b1, 3);
        applyStimulus(1'b0, 1'b0, 4);
        checkOutput("up+down level", int'(level0), 5);
        doLoad(0);
        checkOutput("load 0 clamp", int'(level0), 1);
        doLoad(12);
        checkOutput("load 12 clamp", int'(level0), 8);

        // Reset in the middle of an auto-repeat with the button still held.
        applyStimulus(1'b1, 1'b0, 20);
        reset = 1'b0;
        #1;
        checkOutput("async reset level", int'(level0), 1);
        checkOutput("async reset at_min", int'(atMin0), 1);
        repeat (3) @(posedge clk);
        #2;
        reset = 1'b1;
        applyStimulus(1'b1, 1'b0, 40);
        checkOutput("held through reset", int'(level0), 1);
        applyStimulus(1'b0, 1'b0, 4);
        applyStimulus(1'b1, 1'b0, 3);
        applyStimulus(1'b0, 1'b0, 4);
        checkOutput("press after reset", int'(level0), 2);

        // Random segments of holds, taps and occasional loads.
        for (int s = 0; s < 40; s++) begin
            u   = 1'($urandom_range(0, 1));
            d   = 1'($urandom_range(0, 1));
            len = $urandom_range(1, 40);
            upBtn   = u;
            downBtn = d;
            for (int c = 0; c < len; c++) begin
                load      = ($urandom_range(0, 11) == 0);
                loadLevel = LW'($urandom_range(0, 15));
                @(posedge clk);
                #2;
            end
            load = 1'b0;
        end
        applyStimulus(1'b0, 1'b0, 6);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
